// File: rtl/dtl_sram_target_if.sv
// DTL port bundle between an initiator (master) and a target (slave).
// Handshakes: a beat transfers on the rising edge where the producer's Valid and the consumer's Accept are both high.
interface dtl_sram_target_if #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
);
    logic                             iDTL_CommandValid;
    logic                             oDTL_CommandAccept;
    logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address;
    logic                             iDTL_CommandReadWrite;
    logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize;
    logic                             iDTL_WriteValid;
    logic                             iDTL_WriteLast;
    logic                             oDTL_WriteAccept;
    logic [INTERFACE_NUM_ENABLES-1:0] iDTL_WriteEnable;
    logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData;
    logic                             oDTL_ReadValid;
    logic                             oDTL_ReadLast;
    logic                             iDTL_ReadAccept;
    logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData;

    modport slave (
        input  iDTL_CommandValid, iDTL_Address, iDTL_CommandReadWrite, iDTL_BlockSize,
        input  iDTL_WriteValid, iDTL_WriteLast, iDTL_WriteEnable, iDTL_WriteData,
        input  iDTL_ReadAccept,
        output oDTL_CommandAccept, oDTL_WriteAccept,
        output oDTL_ReadValid, oDTL_ReadLast, oDTL_ReadData
    );

    modport master (
        output iDTL_CommandValid, iDTL_Address, iDTL_CommandReadWrite, iDTL_BlockSize,
        output iDTL_WriteValid, iDTL_WriteLast, iDTL_WriteEnable, iDTL_WriteData,
        output iDTL_ReadAccept,
        input  oDTL_CommandAccept, oDTL_WriteAccept,
        input  oDTL_ReadValid, oDTL_ReadLast, oDTL_ReadData
    );
endinterface

// File: rtl/dtl_sram_target.sv
// DTL target serving single/block reads and writes from a byte-enabled word memory,
// with a two-entry read skid buffer behind a one-cycle synchronous memory read.
module dtl_sram_target #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int MEM_DEPTH             = 1024,
    parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
    input  logic                   iClk,
    input  logic                   iReset,
    dtl_sram_target_if.slave       dtl,
    output logic [1:0]             oDbgState
);
    localparam int OFFSET = $clog2(INTERFACE_NUM_ENABLES);
    localparam int MW     = $clog2(MEM_DEPTH);
    localparam int BW     = INTERFACE_BLOCK_WIDTH;
    localparam int W      = INTERFACE_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    localparam logic [BW:0] CNT_ONE = (BW+1)'(1);

    logic [1:0]    state;
    logic [MW-1:0] addrQ;
    logic [BW-1:0] wrCnt;
    logic [BW:0]   issueLeft;
    logic          inFlight;
    logic          inFlightLast;
    logic [W-1:0]  rdDataQ;
    logic [W-1:0]  bufData [2];
    logic          bufLast [2];
    logic [1:0]    bufCount;

    logic [W-1:0]  mem [MEM_DEPTH];

    logic [MW-1:0] cmdIndex;
    logic          cmdFire;
    logic          wrFire;
    logic          issue;
    logic          readValid;
    logic          pop;
    logic [W-1:0]  seqData [3];
    logic          seqLast [3];
    logic [INTERFACE_ADDR_WIDTH-1:0] unusedAddr;

    assign cmdIndex   = dtl.iDTL_Address[OFFSET +: MW];
    assign unusedAddr = dtl.iDTL_Address;

    assign cmdFire = (state == IDLE) && dtl.iDTL_CommandValid;
    assign wrFire  = (state == WRITE) && dtl.iDTL_WriteValid;
    // Buffer plus in-flight read never exceeds two, so the buffer cannot overflow.
    assign issue   = (state == READ) && (issueLeft != '0) &&
                     ((bufCount + {1'b0, inFlight}) < 2'd2);

    // Ordered view of pending read words: buffered entries first, then the one in flight.
    always_comb begin
        seqData[0] = bufData[0];
        seqData[1] = bufData[1];
        seqData[2] = '0;
        seqLast[0] = bufLast[0];
        seqLast[1] = bufLast[1];
        seqLast[2] = 1'b0;
        if (inFlight) begin
            if (bufCount == 2'd0) begin
                seqData[0] = rdDataQ;
                seqLast[0] = inFlightLast;
            end else begin
                seqData[1] = rdDataQ;
                seqLast[1] = inFlightLast;
            end
        end
    end

    assign readValid = (bufCount != 2'd0) || inFlight;
    assign pop       = readValid && dtl.iDTL_ReadAccept;

    assign dtl.oDTL_CommandAccept = (state == IDLE);
    assign dtl.oDTL_WriteAccept   = (state == WRITE);
    assign dtl.oDTL_ReadValid     = readValid;
    assign dtl.oDTL_ReadLast      = readValid && seqLast[0];
    assign dtl.oDTL_ReadData      = readValid ? seqData[0] : '0;
    assign oDbgState              = state;

    // Memory and its read register carry no reset so they map onto SRAM.
    always_ff @(posedge iClk) begin
        if (wrFire) begin
            for (int b = 0; b < INTERFACE_NUM_ENABLES; b++) begin
                if (dtl.iDTL_WriteEnable[b]) begin
                    mem[addrQ][b*8 +: 8] <= dtl.iDTL_WriteData[b*8 +: 8];
                end
            end
        end
        if (issue) begin
            rdDataQ <= mem[addrQ];
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state        <= IDLE;
            addrQ        <= '0;
            wrCnt        <= '0;
            issueLeft    <= '0;
            inFlight     <= 1'b0;
            inFlightLast <= 1'b0;
            bufData[0]   <= '0;
            bufData[1]   <= '0;
            bufLast[0]   <= 1'b0;
            bufLast[1]   <= 1'b0;
            bufCount     <= 2'd0;
        end else begin
            inFlight <= issue;
            if (issue) begin
                inFlightLast <= (issueLeft == CNT_ONE);
            end

            if (pop) begin
                bufData[0] <= seqData[1];
                bufData[1] <= seqData[2];
                bufLast[0] <= seqLast[1];
                bufLast[1] <= seqLast[2];
            end else begin
                bufData[0] <= seqData[0];
                bufData[1] <= seqData[1];
                bufLast[0] <= seqLast[0];
                bufLast[1] <= seqLast[1];
            end
            bufCount <= bufCount + {1'b0, inFlight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (cmdFire) begin
                        addrQ     <= cmdIndex;
                        wrCnt     <= dtl.iDTL_BlockSize;
                        issueLeft <= {1'b0, dtl.iDTL_BlockSize} + CNT_ONE;
                        state     <= dtl.iDTL_CommandReadWrite ? READ : WRITE;
                    end
                end
                WRITE: begin
                    if (wrFire) begin
                        addrQ <= addrQ + MW'(1);
                        if ((wrCnt == '0) || dtl.iDTL_WriteLast) begin
                            state <= IDLE;
                        end else begin
                            wrCnt <= wrCnt - BW'(1);
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addrQ     <= addrQ + MW'(1);
                        issueLeft <= issueLeft - CNT_ONE;
                    end
                    if (pop && seqLast[0]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dtl_sram_target.sv
// Directed bench for dtl_sram_target: single, byte-enable, burst, early-last, wrap and reset-abort cases.
module tb_dtl_sram_target;
    localparam int W  = 32;
    localparam int AW = 32;
    localparam int BW = 5;
    localparam int NE = 4;

    logic       iClk = 1'b0;
    logic       iReset;
    logic [1:0] dbgState;

    always #5 iClk = ~iClk;

    dtl_sram_target_if #(
        .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(AW),
        .INTERFACE_BLOCK_WIDTH(BW), .INTERFACE_NUM_ENABLES(NE)
    ) dtl ();

    dtl_sram_target #(
        .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(AW), .INTERFACE_BLOCK_WIDTH(BW),
        .MEM_DEPTH(1024), .INTERFACE_NUM_ENABLES(NE)
    ) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .dtl       (dtl),
        .oDbgState (dbgState)
    );

    int checkCnt = 0;
    int passCnt  = 0;

    logic [W-1:0]  wdat [32];
    logic [NE-1:0] wen  [32];
    logic [W-1:0]  edat [32];
    logic [W-1:0]  rdat [$];
    logic          rlast [$];
    int firstValid, firstPop, lastPop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idleInputs();
        dtl.iDTL_CommandValid     = 1'b0;
        dtl.iDTL_Address          = '0;
        dtl.iDTL_CommandReadWrite = 1'b0;
        dtl.iDTL_BlockSize        = '0;
        dtl.iDTL_WriteValid       = 1'b0;
        dtl.iDTL_WriteLast        = 1'b0;
        dtl.iDTL_WriteEnable      = '0;
        dtl.iDTL_WriteData        = '0;
        dtl.iDTL_ReadAccept       = 1'b0;
    endtask

    task automatic writeBurst(input logic [AW-1:0] addr, input logic [BW-1:0] bs,
                              input int n, input int lastIdx);
        @(negedge iClk);
        dtl.iDTL_CommandValid     = 1'b1;
        dtl.iDTL_Address          = addr;
        dtl.iDTL_CommandReadWrite = 1'b0;
        dtl.iDTL_BlockSize        = bs;
        #1 check("wr_cmd_accept", dtl.oDTL_CommandAccept, 1);
        @(posedge iClk);
        @(negedge iClk);
        dtl.iDTL_CommandValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            dtl.iDTL_WriteValid  = 1'b1;
            dtl.iDTL_WriteData   = wdat[i];
            dtl.iDTL_WriteEnable = wen[i];
            dtl.iDTL_WriteLast   = (i == lastIdx);
            #1 check("wr_accept", dtl.oDTL_WriteAccept, 1);
            @(posedge iClk);
            @(negedge iClk);
        end
        dtl.iDTL_WriteValid = 1'b0;
        dtl.iDTL_WriteLast  = 1'b0;
        #1 check("wr_done_idle", dtl.oDTL_CommandAccept, 1);
        check("wr_idle_no_accept", dtl.oDTL_WriteAccept, 0);
    endtask

    task automatic readBurst(input logic [AW-1:0] addr, input logic [BW-1:0] bs,
                             input int n, input logic [3:0] pat);
        int k;
        logic prevStall;
        logic [W-1:0] prevData;
        logic prevLast;
        rdat.delete();
        rlast.delete();
        firstValid = -1; firstPop = -1; lastPop = -1;
        prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
        @(negedge iClk);
        dtl.iDTL_CommandValid     = 1'b1;
        dtl.iDTL_Address          = addr;
        dtl.iDTL_CommandReadWrite = 1'b1;
        dtl.iDTL_BlockSize        = bs;
        #1 check("rd_cmd_accept", dtl.oDTL_CommandAccept, 1);
        @(posedge iClk);
        @(negedge iClk);
        dtl.iDTL_CommandValid = 1'b0;
        k = 1;
        while (rdat.size() < n && k < 200) begin
            dtl.iDTL_ReadAccept = pat[k % 4];
            #1;
            if (dtl.oDTL_ReadValid) begin
                if (firstValid < 0) firstValid = k;
                if (prevStall) begin
                    check("rd_hold_data", dtl.oDTL_ReadData, prevData);
                    check("rd_hold_last", dtl.oDTL_ReadLast, prevLast);
                end
                if (dtl.iDTL_ReadAccept) begin
                    rdat.push_back(dtl.oDTL_ReadData);
                    rlast.push_back(dtl.oDTL_ReadLast);
                    if (firstPop < 0) firstPop = k;
                    lastPop   = k;
                    prevStall = 1'b0;
                end else begin
                    prevStall = 1'b1;
                    prevData  = dtl.oDTL_ReadData;
                    prevLast  = dtl.oDTL_ReadLast;
                end
            end else begin
                if (prevStall) check("rd_hold_valid", dtl.oDTL_ReadValid, 1);
                prevStall = 1'b0;
            end
            @(posedge iClk);
            @(negedge iClk);
            k++;
        end
        dtl.iDTL_ReadAccept = 1'b0;
        check("rd_words", rdat.size(), n);
        check("rd_first_valid", firstValid, 2);
        #1 check("rd_done_idle", dtl.oDTL_CommandAccept, 1);
    endtask

    task automatic verifyRead(input string tag, input int n);
        for (int i = 0; i < n && i < rdat.size(); i++) begin
            check({tag, "_data"}, rdat[i], edat[i]);
            check({tag, "_last"}, rlast[i], (i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checkCnt);
        $fatal(1);
    end

    initial begin
        int pops;
        iReset = 1'b0;
        idleInputs();
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        #1;
        check("rst_cmd_accept", dtl.oDTL_CommandAccept, 1);
        check("rst_wr_accept", dtl.oDTL_WriteAccept, 0);
        check("rst_rd_valid", dtl.oDTL_ReadValid, 0);
        check("rst_rd_last", dtl.oDTL_ReadLast, 0);
        check("rst_rd_data", dtl.oDTL_ReadData, 0);
        check("rst_state", dbgState, 0);
        @(negedge iClk);
        iReset = 1'b1;

        // Single word write then read.
        wdat[0] = 32'hDEADBEEF; wen[0] = 4'hF;
        writeBurst(32'h10, 5'd0, 1, 0);
        readBurst(32'h10, 5'd0, 1, 4'hF);
        edat[0] = 32'hDEADBEEF;
        verifyRead("single", 1);

        // Byte enables merge with the preloaded word.
        wdat[0] = 32'h11223344; wen[0] = 4'hF;
        writeBurst(32'h20, 5'd0, 1, 0);
        wdat[0] = 32'hAABBCCDD; wen[0] = 4'b0101;
        writeBurst(32'h20, 5'd0, 1, 0);
        edat[0] = 32'h11BB33DD;
        readBurst(32'h20, 5'd0, 1, 4'hF);
        verifyRead("byte_en", 1);
        readBurst(32'h23, 5'd0, 1, 4'hF);
        verifyRead("byte_off", 1);

        // Eight-word burst, read back with stalls and then streaming.
        for (int i = 0; i < 8; i++) begin
            wdat[i] = i; wen[i] = 4'hF; edat[i] = i;
        end
        writeBurst(32'h40, 5'd7, 8, 7);
        readBurst(32'h40, 5'd7, 8, 4'b0011);
        verifyRead("burst_stall", 8);
        readBurst(32'h40, 5'd7, 8, 4'hF);
        verifyRead("burst_stream", 8);
        check("rd_stream_span", lastPop - firstPop, 7);

        // Early WriteLast stops the burst after two words.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hA0 + i; wen[i] = 4'hF;
        end
        writeBurst(32'h80, 5'd3, 4, 3);
        wdat[0] = 32'hB0; wdat[1] = 32'hB1;
        writeBurst(32'h80, 5'd3, 2, 1);
        edat[0] = 32'hB0; edat[1] = 32'hB1; edat[2] = 32'hA2; edat[3] = 32'hA3;
        readBurst(32'h80, 5'd3, 4, 4'hF);
        verifyRead("early_last", 4);

        // Wrap from the top word to words 0 and 1.
        wdat[0] = 32'hC0; wdat[1] = 32'hC1; wdat[2] = 32'hC2;
        wen[0] = 4'hF; wen[1] = 4'hF; wen[2] = 4'hF;
        writeBurst(32'hFFC, 5'd2, 3, 2);
        edat[0] = 32'hC0; edat[1] = 32'hC1; edat[2] = 32'hC2;
        readBurst(32'hFFC, 5'd2, 3, 4'hF);
        verifyRead("wrap", 3);
        edat[0] = 32'hC1; edat[1] = 32'hC2;
        readBurst(32'h0, 5'd1, 2, 4'hF);
        verifyRead("wrap_low", 2);

        // Reset while the third word of an eight-word read is presented.
        @(negedge iClk);
        dtl.iDTL_CommandValid     = 1'b1;
        dtl.iDTL_Address          = 32'h40;
        dtl.iDTL_CommandReadWrite = 1'b1;
        dtl.iDTL_BlockSize        = 5'd7;
        @(posedge iClk);
        @(negedge iClk);
        dtl.iDTL_CommandValid = 1'b0;
        dtl.iDTL_ReadAccept   = 1'b1;
        pops = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (dtl.oDTL_ReadValid) begin
                if (pops == 2) break;
                pops++;
            end
            @(posedge iClk);
            @(negedge iClk);
        end
        check("mid_rd_word", dtl.oDTL_ReadData, 2);
        iReset = 1'b0;
        #1;
        check("abort_cmd_accept", dtl.oDTL_CommandAccept, 1);
        check("abort_wr_accept", dtl.oDTL_WriteAccept, 0);
        check("abort_rd_valid", dtl.oDTL_ReadValid, 0);
        check("abort_rd_last", dtl.oDTL_ReadLast, 0);
        check("abort_rd_data", dtl.oDTL_ReadData, 0);
        dtl.iDTL_ReadAccept = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        iReset = 1'b1;
        #1;
        check("post_rst_cmd_accept", dtl.oDTL_CommandAccept, 1);
        check("post_rst_rd_valid", dtl.oDTL_ReadValid, 0);
        check("post_rst_state", dbgState, 0);
        edat[0] = 32'hDEADBEEF;
        readBurst(32'h10, 5'd0, 1, 4'hF);
        verifyRead("post_rst", 1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
